uart_rx: RTL
============

# uart_rx

UART receive engine for the core's UART peripheral, the receiving counterpart of the transmit path. It samples the asynchronous serial line, frames 8N1 characters (1 start bit, 8 data bits LSB first, 1 stop bit, no parity), and presents each byte through a one-entry holding register with a valid/ready handshake. It flags framing errors and overruns to the peripheral's status register.

## Interface
- `CLK_DIV`, default 868: clock cycles per bit. 868 gives 115200 baud at 100 MHz. Legal range is ≥ 4.
- `clk_i`  input  1  system clock; all logic on its rising edge.
- `rst_ni`  input  1  reset. One clock; reset is asynchronous and active-low.
- `rxd_i`  input  1  serial line, asynchronous to `clk_i`, idle high.
- `rx_ready_i`  input  1  consumer accepts the held byte this cycle.
- `rx_data_o`  output  8  held byte; stable while `rx_valid_o` = 1.
- `rx_valid_o`  output  1  holding register full.
- `frame_err_o`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  output  1  one-cycle pulse: a good byte was dropped because the holding register was full.
- `busy_o`  output  1  FSM not in IDLE.

## Operation
- **Input synchronizer:** `rxd_i` passes through a 2-flop synchronizer; both flops reset to 1. All FSM decisions use the synchronized value `rxd_s`.
- **Bit-timing counter:** width $clog2(CLK_DIV). It is reloaded to 0 on every state entry and on every bit sample. The bit index is a 3-bit counter, 0..7.
- **Arm flag:** set whenever `rxd_s` = 1. It is cleared on start detection and after a framing error. Start detection requires armed = 1, so a break or stuck-low line cannot retrigger.
- **IDLE:** if armed and `rxd_s` = 0, go to START. Call this cycle t0.
- **START:** wait CLK_DIV/2 cycles (integer division), then sample `rxd_s`.
  - If the sample is 1 (false start, glitch), go to IDLE with no output activity. Armed is set again by the high line.
  - If the sample is 0, go to DATA with bit index 0.
- **DATA:** wait CLK_DIV cycles, then sample into the shift register, LSB first: bit k lands in data[k]. After bit 7, go to STOP.
- **STOP:** wait CLK_DIV cycles, then sample `rxd_s`.
  - If the sample is 1, the byte is good and goes to the holding register (rules below).
  - If the sample is 0, pulse `frame_err_o`, discard the byte and clear armed.
  - In both cases go to IDLE.
- **Holding register:**
  - Load when a good byte completes and either `rx_valid_o` = 0, or `rx_valid_o` = 1 with `rx_ready_i` = 1 in the same cycle (simultaneous pop and push). In the simultaneous case `rx_valid_o` stays 1 and `rx_data_o` takes the new byte.
  - A pop without a push clears `rx_valid_o` on the next edge.
  - If a good byte completes while full and there is no pop, pulse `overrun_o` and drop the new byte. The old byte stays in the register.
  - `rx_ready_i` while `rx_valid_o` = 0 is ignored.
- **Reset:**
  - On reset: FSM to IDLE, synchronizer to 1, armed to 0, all counters to 0, holding register to 0.
  - Outputs after reset: `rx_data_o` = 0x00, `rx_valid_o` = 0, `frame_err_o` = 0, `overrun_o` = 0, `busy_o` = 0.
  - Reset mid-frame abandons the frame with no pulses. Reception resumes only after the line is seen high.

## Timing
- `rxd_i` to `rxd_s`: 2 cycles.
- Sample instants, relative to t0 (the first IDLE cycle with `rxd_s` = 0):
  - Start bit: t0 + CLK_DIV/2.
  - Data bit k: t0 + CLK_DIV/2 + (k+1)·CLK_DIV.
  - Stop bit: t0 + CLK_DIV/2 + 9·CLK_DIV.
- `rx_valid_o`, `frame_err_o` and `overrun_o` assert in the cycle after the stop sample. The FSM is in IDLE in that same cycle.
- Back-to-back frames: a start edge arriving one cycle after the stop sample is detected. Total frame tolerance is about ±4.5 % clock/baud mismatch.
- Pulses are exactly 1 cycle wide. `busy_o` is high from the cycle after t0 through the stop sample.

## Test plan
- **Basic byte:** CLK_DIV = 16, drive 0xA5 as 8N1 at 16 clocks per bit, `rx_ready_i` = 0 → `rx_valid_o` = 1 and `rx_data_o` = 0xA5, rising 1 cycle after the stop sample. No pulses. Valid holds until `rx_ready_i` = 1, then clears on the next edge.
- **Glitch reject:** 3-cycle low glitch on an idle line → START aborts at the mid-bit sample. `rx_valid_o` and `frame_err_o` stay 0, and the FSM is back in IDLE by t0 + 9.
- **Framing error and break:**
  - Send 0x3C with the stop bit low, then hold the line low for 40 cycles → a single `frame_err_o` pulse, no valid and no retrigger.
  - Release the line high, send 0x81 → `rx_data_o` = 0x81.
- **Overrun:** receive 0x11 and 0x22 back-to-back with `rx_ready_i` = 0 → `overrun_o` pulses once at the second frame's end, and `rx_data_o` stays 0x11.
- **Simultaneous pop and push:** hold 0x11, then assert `rx_ready_i` exactly in the cycle 0x22 completes → no overrun, `rx_valid_o` stays 1 and `rx_data_o` = 0x22.
- **Reset mid-frame:** assert `rst_ni` low during bit 4 of a frame → all outputs 0 immediately. A clean 0x5A sent after release is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake bundle for uart_rx
//
// Signals:
//   rx_data   held byte, stable while rx_valid is high
//   rx_valid  holding register full
//   rx_ready  consumer accepts the held byte this cycle
// Modports:
//   master  receive engine side (drives data/valid)
//   slave   consumer side (drives ready)
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receive engine with one-entry holding register
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   rxd_i        asynchronous serial line, idle high
//   rx           uart_rx_if.master: rx_data / rx_valid / rx_ready
//   frame_err_o  one-cycle pulse, stop bit sampled low
//   overrun_o    one-cycle pulse, good byte dropped because register full
//   busy_o       frame in progress (FSM not idle)
module uart_rx #(
    parameter int CLK_DIV = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    uart_rx_if.master  rx,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // The counter restarts at 0 the cycle after entry/sample, so the sample
    // lands on the cycle where it reaches the wait length minus one.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state;
    logic [1:0]         sync_q;
    logic               rxd_s;
    logic               armed;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
        end
    end

    assign rxd_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            armed       <= 1'b0;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            rx.rx_data  <= 8'h00;
            rx.rx_valid <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;

            // A high line re-arms start detection; a break or stuck-low line
            // after a framing error therefore cannot start a new frame.
            if (rxd_s) begin
                armed <= 1'b1;
            end

            // Pop; a push in the same cycle (STOP below) overrides this.
            if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (armed && !rxd_s) begin
                        state  <= S_START;
                        cnt    <= '0;
                        armed  <= 1'b0;
                        busy_o <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            // Line back high at mid-start: glitch, abandon.
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                        if (rxd_s) begin
                            if (!rx.rx_valid || rx.rx_ready) begin
                                rx.rx_data  <= shreg;
                                rx.rx_valid <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            frame_err_o <= 1'b1;
                            armed       <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
